fp_accum: RTL and testbench

Streaming single-precision accumulator directly downstream of the combinational floating-point multiplier. Consumes a stream of IEEE-754 binary32 products over a valid/ready handshake and sums them into an internal accumulator using a multi-cycle align/add/normalize datapath. Emits the sum and element count when the element flagged `in_last` has been added, then clears for the next stream. Together with the multiplier it forms a dot-product unit.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fp_lzc.sv | 19 +
 rtl/fp_accum.sv | 186 ++++++++++++++++++
 tb/tb_fp_accum.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared binary32 definitions for the floating-point dot-product datapath.
package fpu_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int SIG_W    = 24;
    localparam int SIGN_POS = 31;
    localparam int EXP_LSB  = 23;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [7:0]  FP_BIAS    = 8'h7F;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_NORM   = 2'd2,
        ST_OUT    = 2'd3
    } acc_state_e;

    // Denormals are flushed, so a zero exponent means the value is zero.
    function automatic logic fp_is_zero(input fp32_t x);
        return (x.exp == 8'h00);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational 25-bit leading-zero counter; an all-zero input returns 25.
module fp_lzc (
    input  logic [24:0] din,
    output logic [4:0]  lz
);

    // Highest set bit wins because it is visited last.
    always_comb begin
        lz = 5'd25;
        for (int i = 0; i < 25; i++) begin
            if (din[i]) begin
                lz = 5'(24 - i);
            end else begin
                lz = lz;
            end
        end
    end

endmodule

// File: rtl/fp_accum.sv
// Streaming binary32 accumulator: ACCEPT -> ALIGN -> NORM per product, OUT on the last word.
module fp_accum
    import fpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_sum,
    output logic [CNT_W-1:0]  out_count
);

    acc_state_e       state_q, state_d;
    logic [31:0]      acc_q, acc_d, b_q, b_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      big_sig_q, big_sig_d, sml_sig_q, sml_sig_d;
    logic [7:0]       exp_q, exp_d;
    logic             sign_q, sign_d, sub_q, sub_d;
    logic [31:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    fp32_t       a_s, b_s, big_s, sml_s;
    logic        a_big_s;
    logic [30:0] mag_a_s, mag_b_s;
    logic [23:0] big_sig_s, sml_sig_s;
    logic [7:0]  diff_s;
    logic [24:0] sum_s;
    logic [4:0]  lz_s, sh_s;
    logic [22:0] shl_s, frac_n_s;
    logic [9:0]  exp_n_s;
    logic [31:0] norm_res_s;

    assign in_ready  = (state_q == ST_ACCEPT);
    assign out_valid = (state_q == ST_OUT);
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

    // Align: order operands by magnitude and right-shift the smaller (truncating).
    always_comb begin
        a_s       = fp32_t'(acc_q);
        b_s       = fp32_t'(b_q);
        mag_a_s   = fp_is_zero(a_s) ? 31'd0 : {a_s.exp, a_s.frac};
        mag_b_s   = fp_is_zero(b_s) ? 31'd0 : {b_s.exp, b_s.frac};
        a_big_s   = (mag_a_s >= mag_b_s);
        big_s     = a_big_s ? a_s : b_s;
        sml_s     = a_big_s ? b_s : a_s;
        big_sig_s = fp_is_zero(big_s) ? 24'd0 : {1'b1, big_s.frac};
        sml_sig_s = fp_is_zero(sml_s) ? 24'd0 : {1'b1, sml_s.frac};
        diff_s    = big_s.exp - sml_s.exp;
        if (diff_s >= 8'd24) begin
            sml_sig_s = 24'd0;
        end else begin
            sml_sig_s = sml_sig_s >> diff_s;
        end
    end

    fp_lzc u_lzc (
        .din (sum_s),
        .lz  (lz_s)
    );

    // Normalize: add/subtract, renormalize, then flush underflow and saturate to infinity.
    always_comb begin
        sum_s    = sub_q ? ({1'b0, big_sig_q} - {1'b0, sml_sig_q})
                         : ({1'b0, big_sig_q} + {1'b0, sml_sig_q});
        sh_s     = lz_s - 5'd1;
        shl_s    = sum_s[22:0] << sh_s;
        if (sum_s[24]) begin
            exp_n_s  = {2'b00, exp_q} + 10'd1;
            frac_n_s = sum_s[23:1];
        end else begin
            exp_n_s  = {2'b00, exp_q} - {5'd0, sh_s};
            frac_n_s = shl_s;
        end
        if (sum_s == 25'd0) begin
            norm_res_s = FP_ZERO;
        end else if (exp_n_s[9] || (exp_n_s == 10'd0)) begin
            norm_res_s = FP_ZERO;
        end else if (exp_n_s >= 10'd255) begin
            norm_res_s = {sign_q, FP_EXP_MAX, 23'd0};
        end else begin
            norm_res_s = {sign_q, exp_n_s[7:0], frac_n_s};
        end
    end

    // Next-state and datapath register inputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        b_d         = b_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        big_sig_d   = big_sig_q;
        sml_sig_d   = sml_sig_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        sub_d       = sub_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        case (state_q)
            ST_ACCEPT: begin
                if (in_valid) begin
                    b_d     = in_data;
                    last_d  = in_last;
                    cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                              : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = ST_ALIGN;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_ALIGN: begin
                big_sig_d = big_sig_s;
                sml_sig_d = sml_sig_s;
                exp_d     = big_s.exp;
                sign_d    = big_s.sign;
                sub_d     = (a_s.sign != b_s.sign);
                state_d   = ST_NORM;
            end
            ST_NORM: begin
                acc_d = norm_res_s;
                if (last_q) begin
                    out_sum_d   = norm_res_s;
                    out_count_d = cnt_q;
                    state_d     = ST_OUT;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d       = FP_ZERO;
                    cnt_d       = {CNT_W{1'b0}};
                    last_d      = 1'b0;
                    out_sum_d   = FP_ZERO;
                    out_count_d = {CNT_W{1'b0}};
                    state_d     = ST_ACCEPT;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCEPT;
            acc_q       <= FP_ZERO;
            b_q         <= FP_ZERO;
            last_q      <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
            big_sig_q   <= 24'd0;
            sml_sig_q   <= 24'd0;
            exp_q       <= 8'd0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            out_sum_q   <= FP_ZERO;
            out_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            big_sig_q   <= big_sig_d;
            sml_sig_q   <= sml_sig_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Self-checking bench for fp_accum: directed streams, saturation, backpressure, random streams, mid-stream reset.
module tb_fp_accum;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = 32'd0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;

    int total = 0;
    int bad   = 0;

    fp_accum #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference sum of two binary32 values using integer arithmetic.
    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        longint ka, kb, ma, mb, r;
        int     ea, eb, e, d;
        logic   sa, sb, sr;
        logic [31:0] t;
        ka = (a[30:23] == 8'd0) ? 0 : longint'(a[30:0]);
        kb = (b[30:23] == 8'd0) ? 0 : longint'(b[30:0]);
        if (kb > ka) begin
            t = a; a = b; b = t;
        end
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        sa = a[31]; sb = b[31];
        ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
        mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
        d  = ea - eb;
        mb = (d >= 24) ? 0 : (mb >> d);
        r  = (sa == sb) ? (ma + mb) : (ma - mb);
        sr = sa;
        if (r == 0) return 32'h0;
        e = ea;
        while (r >= (longint'(1) << 24)) begin r = r >> 1; e = e + 1; end
        while (r <  (longint'(1) << 23)) begin r = r << 1; e = e - 1; end
        if (e <= 0) return 32'h0;
        if (e >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, 8'(e), 23'(r)};
    endfunction

    function automatic logic [31:0] rnd_word();
        int          k;
        logic [7:0]  e;
        k = $urandom_range(0, 9);
        case (k)
            0:       e = 8'd0;
            1:       e = 8'($urandom_range(1, 4));
            2:       e = 8'($urandom_range(250, 254));
            default: e = 8'($urandom_range(120, 134));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic send(input logic [31:0] d, input logic l, output bit ok);
        int w;
        w = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        ok = (in_ready === 1'b1);
        if (ok) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(output logic [31:0] s, output logic [CNT_W-1:0] c, output bit ok);
        int w;
        w = 0;
        while (out_valid !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        ok = (out_valid === 1'b1);
        s  = out_sum;
        c  = out_count;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 32'h0 || out_count !== '0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cnt=%0d required 1 0 00000000 0",
                     in_ready, out_valid, out_sum, out_count);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_tbl [12] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'hBF800000,
                                    32'h3F000000, 32'h3E800000, 32'h3E800000, 32'h40400000,
                                    32'h7F000000, 32'h7F000000, 32'h3F800000, 32'h33800000};
        logic [11:0] l_tbl = 12'b1010_1100_1010;
        logic [31:0] s_exp [6] = '{32'h40400000, 32'h00000000, 32'h3F800000,
                                   32'h40400000, 32'h7F800000, 32'h3F800000};
        int          c_exp [6] = '{2, 2, 3, 1, 2, 2};
        logic [31:0] s;
        logic [CNT_W-1:0] c;
        bit ok;
        int k;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            send(d_tbl[i], l_tbl[i], ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL dir_accept[%0d]: in_ready never high, required handshake", i);
            end
            if (l_tbl[i]) begin
                if (i == 1) begin
                    @(posedge clk); #1;
                    total++;
                    if (out_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL dir_latency_early: out_valid=%b required 0", out_valid);
                    end
                    @(posedge clk); #1;
                    total++;
                    if (out_valid !== 1'b1) begin
                        bad++;
                        $display("FAIL dir_latency: out_valid=%b required 1", out_valid);
                    end
                end
                recv(s, c, ok);
                total++;
                if (!ok || s !== s_exp[k] || c !== CNT_W'(c_exp[k])) begin
                    bad++;
                    $display("FAIL dir_stream[%0d]: valid=%b sum=%h cnt=%0d required sum=%h cnt=%0d",
                             k, ok, s, c, s_exp[k], c_exp[k]);
                end
                total++;
                if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_count !== '0) begin
                    bad++;
                    $display("FAIL dir_clear[%0d]: valid=%b sum=%h cnt=%0d required 0 00000000 0",
                             k, out_valid, out_sum, out_count);
                end
                k++;
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] s;
        logic [CNT_W-1:0] c;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            send(32'h3F800000, (i == 9), ok);
        end
        recv(s, c, ok);
        total++;
        if (!ok || s !== 32'h41200000 || c !== 3'd7) begin
            bad++;
            $display("FAIL sat_count: valid=%b sum=%h cnt=%0d required sum=41200000 cnt=7", ok, s, c);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s;
        logic [CNT_W-1:0] c;
        bit ok;
        int w;
        send(32'h3F800000, 1'b1, ok);
        w = 0;
        while (out_valid !== 1'b1 && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        in_data  = 32'h40A00000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h3F800000 || out_count !== 3'd1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b sum=%h cnt=%0d required 1 0 3f800000 1",
                         i, out_valid, in_ready, out_sum, out_count);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_transfer: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        recv(s, c, ok);
        total++;
        if (!ok || s !== 32'h40A00000 || c !== 3'd1) begin
            bad++;
            $display("FAIL bp_next_word: valid=%b sum=%h cnt=%0d required sum=40a00000 cnt=1", ok, s, c);
        end
    endtask

    task automatic test_random();
        logic [31:0] s, acc, w;
        logic [CNT_W-1:0] c;
        bit ok;
        int n;
        for (int t = 0; t < 40; t++) begin
            n   = $urandom_range(1, 9);
            acc = 32'h0;
            for (int i = 0; i < n; i++) begin
                w   = rnd_word();
                acc = m_add(acc, w);
                send(w, (i == n - 1), ok);
            end
            recv(s, c, ok);
            total++;
            if (!ok || s !== acc || c !== CNT_W'((n > 7) ? 7 : n)) begin
                bad++;
                $display("FAIL rand_stream[%0d]: valid=%b sum=%h cnt=%0d required sum=%h cnt=%0d",
                         t, ok, s, c, acc, (n > 7) ? 7 : n);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        logic [CNT_W-1:0] c;
        bit ok;
        send(32'h3F800000, 1'b0, ok);
        send(32'h40000000, 1'b0, ok);
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 32'h0 || out_count !== '0) begin
            bad++;
            $display("FAIL rst_mid: valid=%b in_ready=%b sum=%h cnt=%0d required 0 1 00000000 0",
                     out_valid, in_ready, out_sum, out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h40000000, 1'b1, ok);
        recv(s, c, ok);
        total++;
        if (!ok || s !== 32'h40000000 || c !== 3'd1) begin
            bad++;
            $display("FAIL rst_mid_after: valid=%b sum=%h cnt=%0d required sum=40000000 cnt=1", ok, s, c);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_directed();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
